// File: rtl/seq_decoder_n.sv
// Registered N-to-2^N one-hot decoder with DECODE / ACCUM / SCAN modes and
// valid/ready on both sides; a single output stage fed either by an accept or a scan step.
module seq_decoder_n #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2**N-1:0]  d,
  output logic             out_last,
  output logic             busy
);

  localparam int             W   = 2**N;
  localparam logic [N-1:0]   TOP = '1;
  localparam logic [N-1:0]   ONE = N'(1);
  localparam logic [1:0]     M_ACCUM = 2'b01;
  localparam logic [1:0]     M_SCAN  = 2'b10;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   cur_q, cur_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [W-1:0]   d_q, d_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;

  logic [N-1:0]   idx;
  logic [N-1:0]   cur_inc;
  logic           accept, issue, scan_step;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // x[0] carries the index MSB when MSB_FIRST is set
  generate
    if (MSB_FIRST) begin : g_rev
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign idx[i] = x[N-1-i];
      end
    end else begin : g_fwd
      assign idx = x;
    end
  endgenerate

  assign accept    = in_valid & in_ready;
  assign issue     = out_valid_q & out_ready;
  assign cur_inc   = cur_q + ONE;
  // the TOP compare keeps cur from wrapping past the last index
  assign scan_step = issue & (state_q == S_SCAN) & (cur_q != TOP);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      mask_q      <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      mask_q      <= mask_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    if (accept && mode == M_SCAN)
      state_d = S_SCAN;
    else if (issue && state_q == S_SCAN && cur_q == TOP)
      state_d = S_IDLE;
  end

  // datapath next values
  always_comb begin
    cur_d       = cur_q;
    mask_d      = mask_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (clr)
      mask_d = '0;
    if (accept && mode == M_ACCUM)
      mask_d = (clr ? '0 : mask_q) | onehot(idx);

    if (accept) begin
      out_valid_d = 1'b1;
      case (mode)
        M_ACCUM: begin
          d_d        = mask_d;
          out_last_d = 1'b1;
        end
        M_SCAN: begin
          cur_d      = idx;
          d_d        = onehot(idx);
          out_last_d = (idx == TOP);
        end
        default: begin
          d_d        = onehot(idx);
          out_last_d = 1'b1;
        end
      endcase
    end else if (scan_step) begin
      cur_d      = cur_inc;
      d_d        = onehot(cur_inc);
      out_last_d = (cur_inc == TOP);
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end

  // outputs
  always_comb begin
    in_ready  = rst_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    busy      = (state_q == S_SCAN);
    out_valid = out_valid_q;
    d         = d_q;
    out_last  = out_last_q;
  end

endmodule
